operand2_shift_pipe: RTL and testbench
======================================

// Module: operand2_shift_pipe
// PURPOSE
//  Parametrised, pipelined second-operand (Val2) generator for the EXE stage. Produces shifted/rotated
//  register operands, rotated immediates and memory offsets, plus the shifter carry-out for flag update.
//  Two-stage pipeline with valid/ready handshake on both sides and a flush input for branch squash.
//  Stage 1 decodes the mode and computes the effective amount. Stage 2 performs the shift and carry.
// PARAMETERS
//  DATA_W         32  datapath width; legal values 16, 32, 64
//  TAG_W          4   width of sideband tag carried alongside each operation
//  MEM_OFF_SIGNED 0   1: sign-extend 12-bit memory offset; 0: zero-extend
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  flush      in   1        synchronous squash of all in-flight operations
//  in_valid   in   1        input operation valid
//  in_ready   out  1        unit can accept an operation this cycle
//  in_mode    in   2        00 imm-shift, 01 reg-shift, 10 rotated imm, 11 mem offset
//  in_shop    in   12       shifter-operand field {amt[11:7], type[6:5], x, ...} / {rot[11:8], imm8[7:0]}
//  in_rm      in   DATA_W   Rm value
//  in_rs      in   8        Rs[7:0], register shift amount
//  in_carry   in   1        current C flag
//  in_tag     in   TAG_W    sideband tag, returned unmodified
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_val2   out  DATA_W   Val2 result
//  out_carry  out  1        shifter carry-out
//  out_tag    out  TAG_W    tag of the result
// BEHAVIOUR
//  - Reset/flush: stage valids cleared; out_valid=0, out_val2=0, out_carry=0, out_tag=0 next cycle.
//    flush has priority over in_valid in the same cycle (the input is dropped, not accepted).
//  - Transfer in on in_valid&in_ready; out on out_valid&out_ready. Latency exactly 2 cycles when unstalled.
//  - in_ready = !s1_valid | (!s2_valid | out_ready). Stage regs hold when stalled; no drop, no duplicate.
//  - Full throughput: one op per cycle with out_ready held high; bubbles do not reorder tags.
//  - N = DATA_W; type: 00 LSL, 01 LSR, 10 ASR, 11 ROR. amt_i = in_shop[11:7], amt_r = in_rs.
//  - imm-shift: LSL#0 -> Rm, C=in_carry. LSL#k -> Rm<<k, C=Rm[N-k].
//    LSR#0 means LSR#32 (N=32 encoding): result 0, C=Rm[N-1]. ASR#0: all Rm[N-1], C=Rm[N-1].
//    ROR#0 = RRX: {in_carry, Rm[N-1:1]}, C=Rm[0]. For N=64 imm amounts are 1..31 only.
//  - reg-shift: amt_r==0 -> Rm, C=in_carry for every type.
//    LSL/LSR amt==N: 0, C=Rm[0]/Rm[N-1]; amt>N: 0, C=0. ASR amt>=N: sign fill, C=Rm[N-1].
//    ROR: amt mod N ==0 (amt!=0) -> Rm, C=Rm[N-1]; else rotate by amt mod N, C=result[N-1].
//  - rotated imm: imm8 zero-extended to N, rotated right by (2*rot) mod N; C=in_carry if rot==0
//    else result[N-1].
//  - mem offset: in_shop sign/zero-extended per MEM_OFF_SIGNED; C=in_carry.
//  - in_shop[4] is ignored in modes 00/01 (mode selects imm vs reg shift).
//  - All amounts computed with unsigned arithmetic wide enough for 8-bit amt vs N; no truncation.
// TESTING
//  1. in_mode=00, Rm=0x8000_0001, LSL#1, C=0 -> 2 cycles later val2=0x0000_0002, carry=1.
//  2. in_mode=01, Rm=0x8000_0000, ASR, Rs=0x40 -> val2=0xFFFF_FFFF, carry=1; Rs=0 -> val2=Rm, carry=C.
//  3. in_mode=00, ROR#0 (RRX), Rm=0x0000_0003, C=1 -> val2=0x8000_0001, carry=1.
//  4. in_mode=10, shop=0x2FF -> val2=0xF000_000F, carry=1; shop=0x0FF, C=0 -> 0x0000_00FF, carry=0.
//  5. Stream tags 0..7, out_ready low 3 cycles mid-stream -> in_ready drops, all 8 tags out in order once.
//  6. flush with both stages full and in_valid=1 -> out_valid=0 next cycle, squashed tags never appear.

Source files
------------

// File: rtl/operand2_shift_pipe.sv
// operand2_shift_pipe: two-stage Val2 generator (decode/amount, then shift/carry) with valid/ready and flush.
module operand2_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W = 4,
    parameter bit MEM_OFF_SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [11:0]       in_shop,
    input  logic [DATA_W-1:0] in_rm,
    input  logic [7:0]        in_rs,
    input  logic              in_carry,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val2,
    output logic              out_carry,
    output logic [TAG_W-1:0]  out_tag
);
    localparam logic [7:0] N8 = 8'(DATA_W);
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s1_val_q, s1_val_d, out_val2_q, out_val2_d;
    logic [7:0]        s1_amt_q, s1_amt_d;
    logic [1:0]        s1_typ_q, s1_typ_d;
    logic              s1_rrx_q, s1_rrx_d, s1_cin_q, s1_cin_d, out_carry_q, out_carry_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d, out_tag_q, out_tag_d;
    logic [DATA_W-1:0] dec_val, sh_val, t;
    logic [7:0]        dec_amt;
    logic [1:0]        dec_typ;
    logic              dec_rrx, sh_c, s2_adv, accept;
    int                a, r;
    // Every mode is folded into a reg-shift style (value, type, amount) plus an RRX flag.
    always_comb begin
        dec_val = in_rm;
        dec_typ = in_shop[6:5];
        dec_amt = in_rs;
        dec_rrx = 1'b0;
        if (in_mode == 2'b00) begin
            dec_rrx = in_shop[11:7] == 5'd0 && in_shop[6:5] == 2'b11;
            dec_amt = (in_shop[11:7] == 5'd0 && (in_shop[6:5] == 2'b01 || in_shop[6:5] == 2'b10)) ? N8 : {3'b000, in_shop[11:7]};
        end else if (in_mode == 2'b10) begin
            dec_val = DATA_W'(in_shop[7:0]);
            dec_typ = 2'b11;
            dec_amt = {3'b000, in_shop[11:8], 1'b0};
        end else if (in_mode == 2'b11) begin
            dec_val = {{(DATA_W-12){MEM_OFF_SIGNED && in_shop[11]}}, in_shop};
            dec_typ = 2'b00;
            dec_amt = 8'd0;
        end
    end
    always_comb begin
        a = int'(s1_amt_q);
        r = a % DATA_W;
        t = '0;
        sh_val = s1_val_q;
        sh_c = s1_cin_q;
        if (s1_rrx_q) begin
            sh_val = {s1_cin_q, s1_val_q[DATA_W-1:1]};
            sh_c = s1_val_q[0];
        end else if (a == 0) begin
            sh_val = s1_val_q;
            sh_c = s1_cin_q;
        end else if (s1_typ_q == 2'b00) begin
            sh_val = (a < DATA_W) ? s1_val_q << a : '0;
            t = s1_val_q >> (DATA_W - a);
            sh_c = (a <= DATA_W) ? t[0] : 1'b0;
        end else if (s1_typ_q == 2'b01) begin
            sh_val = (a < DATA_W) ? s1_val_q >> a : '0;
            t = s1_val_q >> (a - 1);
            sh_c = (a <= DATA_W) ? t[0] : 1'b0;
        end else if (s1_typ_q == 2'b10) begin
            sh_val = (a < DATA_W) ? DATA_W'($signed(s1_val_q) >>> a) : {DATA_W{s1_val_q[DATA_W-1]}};
            t = s1_val_q >> ((a < DATA_W) ? a - 1 : DATA_W - 1);
            sh_c = t[0];
        end else begin
            sh_val = (r == 0) ? s1_val_q : (s1_val_q >> r) | (s1_val_q << (DATA_W - r));
            sh_c = sh_val[DATA_W-1];
        end
    end
    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept = in_valid && in_ready && !flush;
        s1_valid_d = flush ? 1'b0 : accept || (s1_valid_q && !s2_adv);
        s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
        s1_val_d = accept ? dec_val : s1_val_q;
        s1_amt_d = accept ? dec_amt : s1_amt_q;
        s1_typ_d = accept ? dec_typ : s1_typ_q;
        s1_rrx_d = accept ? dec_rrx : s1_rrx_q;
        s1_cin_d = accept ? in_carry : s1_cin_q;
        s1_tag_d = accept ? in_tag : s1_tag_q;
        out_val2_d = flush ? '0 : (s2_adv && s1_valid_q) ? sh_val : out_val2_q;
        out_carry_d = flush ? 1'b0 : (s2_adv && s1_valid_q) ? sh_c : out_carry_q;
        out_tag_d = flush ? '0 : (s2_adv && s1_valid_q) ? s1_tag_q : out_tag_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_val_q <= '0;
            s1_amt_q <= '0;
            s1_typ_q <= '0;
            s1_rrx_q <= 1'b0;
            s1_cin_q <= 1'b0;
            s1_tag_q <= '0;
            out_val2_q <= '0;
            out_carry_q <= 1'b0;
            out_tag_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_val_q <= s1_val_d;
            s1_amt_q <= s1_amt_d;
            s1_typ_q <= s1_typ_d;
            s1_rrx_q <= s1_rrx_d;
            s1_cin_q <= s1_cin_d;
            s1_tag_q <= s1_tag_d;
            out_val2_q <= out_val2_d;
            out_carry_q <= out_carry_d;
            out_tag_q <= out_tag_d;
        end
    end
    assign out_valid = s2_valid_q;
    assign out_val2 = out_val2_q;
    assign out_carry = out_carry_q;
    assign out_tag = out_tag_q;
endmodule

// File: tb/tb_operand2_shift_pipe.sv
// tb_operand2_shift_pipe: directed vectors for the Val2 pipe, checked with immediate assertions.
module tb_operand2_shift_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [11:0] in_shop = '0;
    logic [31:0] in_rm = '0;
    logic [7:0]  in_rs = '0;
    logic        in_carry = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_val2;
    logic        out_carry;
    logic [3:0]  out_tag;
    int total = 0;
    int bad = 0;

    operand2_shift_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_shop(in_shop), .in_rm(in_rm), .in_rs(in_rs), .in_carry(in_carry),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_val2(out_val2),
        .out_carry(out_carry), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, o, e);
        end
    endtask

    task automatic single(input string nm, input logic [1:0] m, input logic [11:0] shop,
                          input logic [31:0] rm, input logic [7:0] rs, input logic c,
                          input logic [3:0] tg, input logic [31:0] ev, input logic ec);
        @(negedge clk);
        in_valid = 1'b1; in_mode = m; in_shop = shop; in_rm = rm; in_rs = rs; in_carry = c; in_tag = tg;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_val2"}, 64'(out_val2), 64'(ev));
        chk({nm, "_carry"}, 64'(out_carry), 64'(ec));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tg));
    endtask

    initial begin
        int sent, recv;
        bit dropped, seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_val2", 64'(out_val2), 64'd0);
        chk("rst_carry", 64'(out_carry), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        single("lsl1", 2'b00, 12'h080, 32'h8000_0001, 8'h00, 1'b0, 4'h1, 32'h0000_0002, 1'b1);
        single("asr64", 2'b01, 12'h040, 32'h8000_0000, 8'h40, 1'b0, 4'h2, 32'hFFFF_FFFF, 1'b1);
        single("asr_rs0", 2'b01, 12'h040, 32'h8000_0000, 8'h00, 1'b0, 4'h3, 32'h8000_0000, 1'b0);
        single("rrx", 2'b00, 12'h060, 32'h0000_0003, 8'h00, 1'b1, 4'h4, 32'h8000_0001, 1'b1);
        single("rotimm2", 2'b10, 12'h2FF, 32'h1234_5678, 8'h00, 1'b0, 4'h5, 32'hF000_000F, 1'b1);
        single("rotimm0", 2'b10, 12'h0FF, 32'h1234_5678, 8'h00, 1'b0, 4'h6, 32'h0000_00FF, 1'b0);
        single("lsr0", 2'b00, 12'h020, 32'h8000_0000, 8'h00, 1'b0, 4'h7, 32'h0000_0000, 1'b1);
        single("lsr4", 2'b00, 12'h230, 32'h0000_00F8, 8'h00, 1'b0, 4'h8, 32'h0000_000F, 1'b1);
        single("lsl_r32", 2'b01, 12'h000, 32'h0000_0001, 8'd32, 1'b0, 4'h9, 32'h0000_0000, 1'b1);
        single("lsr_r33", 2'b01, 12'h020, 32'hFFFF_FFFF, 8'd33, 1'b1, 4'hA, 32'h0000_0000, 1'b0);
        single("ror_r32", 2'b01, 12'h060, 32'h8000_0000, 8'd32, 1'b0, 4'hB, 32'h8000_0000, 1'b1);
        single("ror_r36", 2'b01, 12'h060, 32'h0000_001F, 8'd36, 1'b0, 4'hC, 32'hF000_0001, 1'b1);
        single("memoff", 2'b11, 12'hABC, 32'hFFFF_FFFF, 8'h00, 1'b1, 4'hD, 32'h0000_0ABC, 1'b1);

        sent = 0; recv = 0; dropped = 1'b0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            in_valid = sent < 8;
            in_mode = 2'b11; in_shop = 12'(sent * 17); in_tag = 4'(sent); in_carry = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                chk("stream_tag", 64'(out_tag), 64'(recv));
                chk("stream_val2", 64'(out_val2), 64'(recv * 17));
                recv++;
            end
            if (in_valid && !in_ready) dropped = 1'b1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(recv), 64'd8);
        chk("stream_backpressure", 64'(dropped), 64'd1);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("stream_no_dup", 64'(seen), 64'd0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b11; in_shop = 12'h123; in_carry = 1'b1; in_tag = 4'h9;
        @(negedge clk);
        in_shop = 12'h456; in_tag = 4'hA;
        @(negedge clk);
        chk("fill_ready", 64'(in_ready), 64'd0);
        chk("fill_tag", 64'(out_tag), 64'h9);
        flush = 1'b1; out_ready = 1'b1; in_shop = 12'h789; in_tag = 4'hB;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_val2", 64'(out_val2), 64'd0);
        chk("flush_carry", 64'(out_carry), 64'd0);
        chk("flush_tag", 64'(out_tag), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("flush_squashed", 64'(seen), 64'd0);
        single("post_flush", 2'b00, 12'h080, 32'h4000_0000, 8'h00, 1'b1, 4'hE, 32'h8000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
